// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches, presents
// {instruction, pc_out} to decode through a valid/stall output register,
// keeps one spare word in a skid buffer and squashes wrong-path fetches.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [DATA_W-1:0] instruction,
    output logic [31:0]       pc_out,
    output logic              instr_valid,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_BUF,
        S_DRAIN,
        S_HALT
    } state_t;

    localparam logic [5:0] HALT_OP = 6'b111111;

    // Clear the two byte-offset bits so every PC is a word address.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    // HALT is recognised purely on the major opcode field.
    function automatic logic is_halt(input logic [DATA_W-1:0] w);
        return w[DATA_W-1 -: 6] == HALT_OP;
    endfunction

    state_t            state;
    logic [31:0]       pc;
    logic [31:0]       target;
    logic [DATA_W-1:0] skid_instr;
    logic [31:0]       skid_pc;

    logic [DATA_W-1:0] instr_p0;
    logic [31:0]       pc_p0;
    logic              vld_p0;
    logic              halted_q;

    logic              free;
    logic [31:0]       redir_al;
    logic              ld_from_mem;
    logic              ld_from_skid;
    logic              ld_skid;

    assign free     = !vld_p0 || !stall;
    assign redir_al = align_word(redirect_pc);

    // Request is gated by rst_n so nothing is driven to memory during reset.
    assign imem_req  = rst_n && ((state == S_FETCH) || (state == S_DRAIN));
    assign imem_addr = align_word(pc);

    assign instruction = instr_p0;
    assign pc_out      = pc_p0;
    assign instr_valid = vld_p0;
    assign halted      = halted_q;

    // Datapath load enables; a redirect suppresses every load.
    always_comb begin
        ld_from_mem  = 1'b0;
        ld_from_skid = 1'b0;
        ld_skid      = 1'b0;
        if (!redirect) begin
            if (state == S_FETCH && imem_ack) begin
                ld_from_mem = free;
                ld_skid     = !free;
            end
            if (state == S_BUF && free) begin
                ld_from_skid = 1'b1;
            end
        end
    end

    // Control: state, PC, pending redirect target, valid and halted flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= align_word(RESET_PC);
            target   <= 32'h0;
            vld_p0   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (redirect) begin
                        vld_p0 <= 1'b0;
                        if (imem_ack) begin
                            pc <= redir_al;
                        end else begin
                            // Request already on the bus must complete first.
                            target <= redir_al;
                            state  <= S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc <= pc + 32'd4;
                        if (free) begin
                            vld_p0 <= 1'b1;
                            state  <= is_halt(imem_rdata) ? S_HALT : S_FETCH;
                        end else begin
                            state <= S_BUF;
                        end
                    end else if (free) begin
                        vld_p0 <= 1'b0;
                    end
                end
                S_BUF: begin
                    if (redirect) begin
                        vld_p0 <= 1'b0;
                        pc     <= redir_al;
                        state  <= S_FETCH;
                    end else if (free) begin
                        vld_p0 <= 1'b1;
                        state  <= is_halt(skid_instr) ? S_HALT : S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (redirect || free) begin
                        vld_p0 <= 1'b0;
                    end
                    if (imem_ack) begin
                        pc    <= redirect ? redir_al : target;
                        state <= S_FETCH;
                    end else if (redirect) begin
                        target <= redir_al;
                    end
                end
                S_HALT: begin
                    if (redirect) begin
                        // The HALT was on a wrong path: resume fetching.
                        vld_p0   <= 1'b0;
                        halted_q <= 1'b0;
                        pc       <= redir_al;
                        state    <= S_FETCH;
                    end else begin
                        halted_q <= 1'b1;
                        if (free) begin
                            vld_p0 <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Data: output register and skid buffer, loaded only on their enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p0   <= '0;
            pc_p0      <= 32'h0;
            skid_instr <= '0;
            skid_pc    <= 32'h0;
        end else begin
            if (ld_from_mem) begin
                instr_p0 <= imem_rdata;
                pc_p0    <= pc;
            end else if (ld_from_skid) begin
                instr_p0 <= skid_instr;
                pc_p0    <= skid_pc;
            end
            if (ld_skid) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized latency/stall/redirect
// traffic, checked by a program-order scoreboard and protocol monitor.
module tb_if_stage;

    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
    localparam logic [31:0] NO_HALT   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        halted;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_pc_out;
    logic        w_valid;
    logic        w_halted;

    int checks = 0;
    int errors = 0;

    logic [31:0] halt_addr = NO_HALT;
    int unsigned lat_left = 0;
    int unsigned fix_lat = 0;
    int unsigned max_lat = 0;
    bit          use_fix = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instruction(instruction), .pc_out(pc_out),
        .instr_valid(instr_valid), .halted(halted)
    );

    // Second instance exercising PC wrap-around, zero-latency memory.
    assign w_rdata = {6'b000000, w_addr[25:0]};
    if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_req), .imem_rdata(w_rdata),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .instruction(w_instr), .pc_out(w_pc_out),
        .instr_valid(w_valid), .halted(w_halted)
    );

    // Program image: HALT at halt_addr, otherwise an address-derived word.
    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (a == halt_addr) return HALT_WORD;
        return {6'b000010, a[27:2] ^ 26'h2AA_AAAA};
    endfunction

    function automatic int unsigned pick_lat();
        if (use_fix) return fix_lat;
        return $urandom_range(max_lat, 0);
    endfunction

    always_comb imem_rdata = ref_word(imem_addr);
    assign imem_ack = imem_req && (lat_left == 0);

    // Memory latency counter: a fresh latency is drawn for every request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lat_left <= pick_lat();
        else if (imem_req) begin
            if (imem_ack) lat_left <= pick_lat();
            else          lat_left <= lat_left - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Expected architectural stream from a start address up to a HALT.
    task automatic refill(input logic [31:0] start);
        logic [31:0] a;
        exp_q.delete();
        a = start & 32'hFFFF_FFFC;
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back({a, ref_word(a)});
            if (a == halt_addr) break;
            a = a + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] t, input logic [31:0] h);
        redirect    = 1'b1;
        redirect_pc = t;
        @(posedge clk);
        #1;
        redirect  = 1'b0;
        halt_addr = h;
        refill(t);
    endtask

    // Monitor: consumes outputs against the scoreboard and checks protocol.
    initial begin
        logic        prev_req = 1'b0;
        logic        prev_ack = 1'b0;
        logic        prev_redir = 1'b0;
        logic [31:0] prev_addr = 32'h0;
        logic        halt_armed = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req   = 1'b0;
                prev_redir = 1'b0;
                halt_armed = 1'b0;
            end else begin
                if (prev_redir) begin
                    check("valid_after_redirect", {31'b0, instr_valid}, 32'd0);
                    check("halted_after_redirect", {31'b0, halted}, 32'd0);
                end
                if (prev_req && !prev_ack) begin
                    check("req_held", {31'b0, imem_req}, 32'd1);
                    check("addr_held", imem_addr, prev_addr);
                end
                if (halt_armed) begin
                    check("halted_set", {31'b0, halted}, 32'd1);
                    check("no_req_halted", {31'b0, imem_req}, 32'd0);
                end
                if (imem_req) check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
                if (instr_valid && !stall) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr actual=pc %h required=none", pc_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("pc_out", pc_out, e.pc);
                        check("instruction", instruction, e.ins);
                        if (e.ins == HALT_WORD && !redirect) halt_armed = 1'b1;
                    end
                end
                if (redirect) halt_armed = 1'b0;
                prev_redir = redirect;
                prev_req   = imem_req;
                prev_ack   = imem_ack;
                prev_addr  = imem_addr;
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        int n;
        logic [31:0] t;
        logic [31:0] h;
        int stall_pct;

        halt_addr = 32'd20;
        use_fix   = 1'b1;
        fix_lat   = 0;
        #1;
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        refill(32'h0);
        #1;
        check("req_after_release", {31'b0, imem_req}, 32'd1);
        check("addr_after_release", imem_addr, 32'h0);
        check("valid_after_release", {31'b0, instr_valid}, 32'd0);

        // Zero-latency streaming, and the wrap-around instance.
        tick();
        check("stream0_valid", {31'b0, instr_valid}, 32'd1);
        check("stream0_pc", pc_out, 32'h0);
        check("wrap0_pc", w_pc_out, 32'hFFFF_FFF8);
        tick();
        check("stream1_pc", pc_out, 32'h4);
        check("wrap1_pc", w_pc_out, 32'hFFFF_FFFC);
        tick();
        check("stream2_pc", pc_out, 32'h8);
        check("wrap2_pc", w_pc_out, 32'h0);
        check("wrap2_valid", {31'b0, w_valid}, 32'd1);

        // Stall three cycles holding PC 8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_pc", pc_out, 32'h8);
            check("stall_hold_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_no_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check("skid_out_pc", pc_out, 32'hC);
        check("post_skid_req", {31'b0, imem_req}, 32'd1);
        check("post_skid_addr", imem_addr, 32'h10);

        // HALT word at PC 20.
        tick();
        check("pre_halt_pc", pc_out, 32'h10);
        tick();
        check("halt_pc", pc_out, 32'h14);
        check("halt_instr", instruction, HALT_WORD);
        check("halt_not_yet", {31'b0, halted}, 32'd0);
        check("halt_no_req", {31'b0, imem_req}, 32'd0);
        tick();
        check("halted_next", {31'b0, halted}, 32'd1);
        check("halt_drained", {31'b0, instr_valid}, 32'd0);
        tick();
        check("halt_still_no_req", {31'b0, imem_req}, 32'd0);
        do_redirect(32'h40, NO_HALT);
        fix_lat = 3;
        check("resume_halted", {31'b0, halted}, 32'd0);
        check("resume_req", {31'b0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'h40);
        tick();
        check("resume_pc", pc_out, 32'h40);

        // Three-cycle latency, redirect during the second waiting cycle.
        tick();
        do_redirect(32'h100, NO_HALT);
        check("drain_addr", imem_addr, 32'h44);
        check("drain_req", {31'b0, imem_req}, 32'd1);
        n = 0;
        while (!imem_ack && n < 10) begin
            tick();
            n++;
            check("drain_addr_wait", imem_addr, 32'h44);
            check("drain_no_valid", {31'b0, instr_valid}, 32'd0);
        end
        check("drain_ack_seen", {31'b0, imem_ack}, 32'd1);
        tick();
        check("redir_req", {31'b0, imem_req}, 32'd1);
        check("redir_addr", imem_addr, 32'h100);
        check("redir_no_valid", {31'b0, instr_valid}, 32'd0);

        // Reset while draining a squashed request with decode stalled.
        fix_lat = 0;
        repeat (6) tick();
        stall   = 1'b1;
        fix_lat = 3;
        repeat (6) tick();
        do_redirect(32'h200, NO_HALT);
        do_redirect(32'h300, NO_HALT);
        check("pre_rst_req", {31'b0, imem_req}, 32'd1);
        check("pre_rst_addr", imem_addr, 32'h200);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'b0, instr_valid}, 32'd0);
        check("midrst_instr", instruction, 32'd0);
        check("midrst_pc_out", pc_out, 32'd0);
        check("midrst_halted", {31'b0, halted}, 32'd0);
        check("midrst_req", {31'b0, imem_req}, 32'd0);
        stall   = 1'b0;
        fix_lat = 0;
        tick();
        rst_n = 1'b1;
        refill(32'h0);
        #1;
        check("restart_req", {31'b0, imem_req}, 32'd1);
        check("restart_addr", imem_addr, 32'h0);
        tick();
        check("restart_pc", pc_out, 32'h0);

        // Randomized traffic.
        use_fix = 1'b0;
        for (int seg = 0; seg < 30; seg++) begin
            max_lat   = $urandom_range(3, 0);
            stall_pct = $urandom_range(60, 0);
            if (seg % 5 == 0) t = 32'hFFFF_FF00 + 32'(4 * $urandom_range(60, 0));
            else              t = $urandom & 32'h000F_FFFC;
            h = ($urandom_range(1, 0) == 1) ? t + 32'(4 * $urandom_range(30, 0)) : NO_HALT;
            do_redirect(t | 32'($urandom_range(3, 0)), h);
            n = $urandom_range(80, 20);
            for (int c = 0; c < n; c++) begin
                stall = ($urandom_range(99, 0) < stall_pct);
                if ($urandom_range(99, 0) < 4) begin
                    t = $urandom & 32'h000F_FFFC;
                    do_redirect(t, NO_HALT);
                end else begin
                    tick();
                end
            end
        end
        stall = 1'b0;
        repeat (10) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
